// File: rtl/ret_pwr_ctrl.sv
// ret_pwr_ctrl: always-on power sequencer for one retention domain.
// Drives clock gate, isolation, SAVE/NRESTORE and the power switch, and
// watches PWR_GOOD with a shared saturating cycle counter for timeouts.
module ret_pwr_ctrl #(
  parameter int unsigned SAVE_CYC    = 2,
  parameter int unsigned RESTORE_CYC = 2,
  parameter int unsigned PWR_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       CP,
  input  logic       CDN,
  input  logic       PD_REQ,
  input  logic       PWR_GOOD,
  output logic       PD_ACK,
  output logic       CLK_EN,
  output logic       ISO_EN,
  output logic       SAVE,
  output logic       NRESTORE,
  output logic       PWR_EN,
  output logic       ERR,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    ST_ON       = 4'd0,
    ST_CLK_STOP = 4'd1,
    ST_ISOLATE  = 4'd2,
    ST_SAVE     = 4'd3,
    ST_PWR_DN   = 4'd4,
    ST_OFF      = 4'd5,
    ST_PWR_UP   = 4'd6,
    ST_RESTORE  = 4'd7,
    ST_DEISO    = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] SAVE_LAST    = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] RESTORE_LAST = CNT_W'(RESTORE_CYC - 1);
  // Counter starts at 0 on state entry, so the edge that would take it to
  // PWR_TIMEOUT is the one where it currently holds PWR_TIMEOUT-1.
  localparam logic [CNT_W-1:0] TMO_LAST     = CNT_W'(PWR_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             clk_en_d, iso_en_d, save_d, nrestore_d, pwr_en_d, pd_ack_d;
  logic             timeout;

  assign timeout = (cnt_q == TMO_LAST);

  // Next-state, sticky error and counter update.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ON:       if (PD_REQ) state_d = ST_CLK_STOP;
      ST_CLK_STOP: state_d = ST_ISOLATE;
      ST_ISOLATE:  state_d = ST_SAVE;
      ST_SAVE:     if (cnt_q == SAVE_LAST) state_d = ST_PWR_DN;
      ST_PWR_DN: begin
        if (!PWR_GOOD) begin
          state_d = ST_OFF;
        end else if (timeout) begin
          state_d = ST_OFF;
          err_d   = 1'b1;
        end
      end
      ST_OFF:      if (!PD_REQ) state_d = ST_PWR_UP;
      ST_PWR_UP: begin
        if (PWR_GOOD)     state_d = ST_RESTORE;
        else if (timeout) err_d   = 1'b1;
      end
      ST_RESTORE:  if (cnt_q == RESTORE_LAST) state_d = ST_DEISO;
      ST_DEISO:    state_d = ST_ON;
      default:     state_d = ST_ON;
    endcase
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Output decode of the next state; registered below so each output is a
  // flop that tracks the state register exactly.
  always_comb begin
    clk_en_d   = 1'b0;
    iso_en_d   = 1'b1;
    save_d     = 1'b0;
    nrestore_d = 1'b1;
    pwr_en_d   = 1'b1;
    pd_ack_d   = 1'b0;
    unique case (state_d)
      ST_ON:       begin clk_en_d = 1'b1; iso_en_d = 1'b0; end
      ST_CLK_STOP: iso_en_d   = 1'b0;
      ST_ISOLATE:  ;
      ST_SAVE:     save_d     = 1'b1;
      ST_PWR_DN:   pwr_en_d   = 1'b0;
      ST_OFF:      begin pwr_en_d = 1'b0; pd_ack_d = 1'b1; end
      ST_PWR_UP:   ;
      ST_RESTORE:  nrestore_d = 1'b0;
      ST_DEISO:    iso_en_d   = 1'b0;
      default:     begin clk_en_d = 1'b1; iso_en_d = 1'b0; end
    endcase
  end

  // State, counter, error and output registers with asynchronous reset.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q  <= ST_ON;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      CLK_EN   <= 1'b1;
      ISO_EN   <= 1'b0;
      SAVE     <= 1'b0;
      NRESTORE <= 1'b1;
      PWR_EN   <= 1'b1;
      PD_ACK   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      CLK_EN   <= clk_en_d;
      ISO_EN   <= iso_en_d;
      SAVE     <= save_d;
      NRESTORE <= nrestore_d;
      PWR_EN   <= pwr_en_d;
      PD_ACK   <= pd_ack_d;
    end
  end

  assign ERR   = err_q;
  assign STATE = state_q;

endmodule
